// File: rtl/ula_seq_ctrl.sv
// Registered ALU-op decoder with a valid/ready front end that sequences
// multi-cycle MULT/DIVI operations and back-pressures the control unit.
module ula_seq_ctrl #(
    parameter int unsigned OP_W     = 6,
    parameter int unsigned MUL_LAT  = 4,
    parameter int unsigned DIV_LAT  = 8,
    parameter int unsigned MULTI_EN = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [5:0]      opcode,
    input  logic [5:0]      opex,
    input  logic [3:0]      ctrl,
    input  logic            flush,
    output logic [OP_W-1:0] alu_op,
    output logic            issue,
    output logic            busy,
    output logic            done
);

    localparam int unsigned D_W     = 5;
    localparam int unsigned MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);

    localparam logic [D_W-1:0] OP_ADD  = 5'h00;
    localparam logic [D_W-1:0] OP_MULT = 5'h02;
    localparam logic [D_W-1:0] OP_DIVI = 5'h03;
    localparam logic [D_W-1:0] OP_MOVE = 5'h10;
    localparam logic [D_W-1:0] OP_NOP  = 5'h1F;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [D_W-1:0]   d_c;
    logic [CNT_W-1:0] lat_m1_c;
    logic             accept_c;

    // Operation decode; earlier branches take priority.
    always_comb begin
        d_c = OP_NOP;
        if (ctrl[0] | ctrl[1]) begin
            d_c = OP_NOP;
        end else if (ctrl[3]) begin
            d_c = OP_ADD;
        end else if ((opcode[5:4] == 2'b10) || (opcode[5:3] == 3'b110)) begin
            d_c = OP_NOP;
        end else if (ctrl[2]) begin
            if (opcode == 6'h39) begin
                d_c = OP_MOVE;
            end else if (opcode[4:1] == 4'b1000) begin
                d_c = OP_NOP;
            end else begin
                d_c = {1'b0, opcode[3:0]};
            end
        end else begin
            if ((opex >= 6'h14) && (opex <= 6'h19)) begin
                d_c = OP_MOVE;
            end else if (opex < 6'h12) begin
                d_c = opex[4:0];
            end else begin
                d_c = {1'b0, opex[3:0]};
            end
        end
    end

    // Extra occupancy beyond the issue cycle; zero means single-cycle.
    always_comb begin
        lat_m1_c = '0;
        if (MULTI_EN != 0) begin
            if (d_c == OP_MULT) begin
                lat_m1_c = CNT_W'(MUL_LAT - 1);
            end else if (d_c == OP_DIVI) begin
                lat_m1_c = CNT_W'(DIV_LAT - 1);
            end
        end
    end

    assign accept_c = in_valid & in_ready & ~flush;

    // Sequencer; all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            alu_op   <= OP_W'(OP_NOP);
            issue    <= 1'b0;
            done     <= 1'b0;
            busy     <= 1'b0;
            in_ready <= 1'b1;
        end else begin
            issue <= 1'b0;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept_c) begin
                        alu_op <= OP_W'(d_c);
                        issue  <= 1'b1;
                        if (lat_m1_c == '0) begin
                            done <= 1'b1;
                        end else begin
                            state    <= BUSY;
                            cnt      <= lat_m1_c;
                            busy     <= 1'b1;
                            in_ready <= 1'b0;
                        end
                    end
                end
                BUSY: begin
                    // Flush beats completion, so an aborted op never signals done.
                    if (flush) begin
                        state    <= IDLE;
                        cnt      <= '0;
                        busy     <= 1'b0;
                        in_ready <= 1'b1;
                    end else if (cnt == CNT_W'(1)) begin
                        state    <= IDLE;
                        cnt      <= '0;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        in_ready <= 1'b1;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state    <= IDLE;
                    cnt      <= '0;
                    busy     <= 1'b0;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ula_seq_ctrl.sv
// Scoreboard bench for ula_seq_ctrl: a multi-cycle instance plus a
// MULTI_EN=0 instance sharing the same stimulus.
module tb_ula_seq_ctrl;

    localparam int unsigned MUL_LAT = 4;
    localparam int unsigned DIV_LAT = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [5:0] opcode;
    logic [5:0] opex;
    logic [3:0] ctrl;
    logic       flush;

    logic       in_ready, issue, busy, done;
    logic [5:0] alu_op;
    logic       in_ready_se, issue_se, busy_se, done_se;
    logic [5:0] alu_op_se;

    ula_seq_ctrl #(.OP_W(6), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .MULTI_EN(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .opex(opex), .ctrl(ctrl), .flush(flush),
        .alu_op(alu_op), .issue(issue), .busy(busy), .done(done)
    );

    ula_seq_ctrl #(.OP_W(6), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .MULTI_EN(0)) u_dut_se (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_se),
        .opcode(opcode), .opex(opex), .ctrl(ctrl), .flush(flush),
        .alu_op(alu_op_se), .issue(issue_se), .busy(busy_se), .done(done_se)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] op;
        int         lat;
    } exp_t;

    typedef struct {
        logic [5:0] opcode;
        logic [5:0] opex;
        logic [3:0] ctrl;
        logic [5:0] op;
        int         lat;
    } vec_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    bit   mon_en   = 1'b0;
    bit   act      = 1'b0;
    int   rem      = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: pops the expected op on issue and tracks done/busy timing.
    always @(negedge clk) begin
        if (mon_en) begin
            if (!rst_n) begin
                act = 1'b0;
                check("rst_busy", 32'(busy), 32'd0);
                check("rst_done", 32'(done), 32'd0);
            end else begin
                if (issue) begin
                    if (sb_q.size() == 0) begin
                        check("unexp_issue", 32'(issue), 32'd0);
                    end else begin
                        mon_e = sb_q.pop_front();
                        check("alu_op", 32'(alu_op), 32'(mon_e.op));
                        act = 1'b1;
                        rem = mon_e.lat - 1;
                    end
                end
                check("done", 32'(done), 32'(act && rem == 0));
                check("busy", 32'(busy), 32'(act && rem > 0));
                check("in_ready", 32'(in_ready), 32'(!(act && rem > 0)));
                check("se_busy", 32'(busy_se), 32'd0);
                if (act) begin
                    if (rem == 0 || flush) act = 1'b0;
                    else rem = rem - 1;
                end
            end
        end
    end

    // Drive one request and hold it until accepted; returns the accept cycle.
    task automatic send(input logic [5:0] oc, input logic [5:0] ox, input logic [3:0] ct,
                        input logic [5:0] eop, input int lat, output int acc);
        exp_t e;
        opcode   = oc;
        opex     = ox;
        ctrl     = ct;
        in_valid = 1'b1;
        acc      = -1;
        for (int i = 0; i < 64; i++) begin
            if (in_ready && !flush) begin
                e.op  = eop;
                e.lat = lat;
                sb_q.push_back(e);
                acc = cyc;
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        check("accept_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    vec_t vecs[$];
    int   a1, a2;

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        opcode   = '0;
        opex     = '0;
        ctrl     = '0;
        flush    = 1'b0;

        #12;
        check("reset_alu_op", 32'(alu_op), 32'h1F);
        check("reset_issue", 32'(issue), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_se_alu_op", 32'(alu_op_se), 32'h1F);
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        // Decode table: opcode, opex, ctrl, expected op, latency
        vecs.push_back('{6'h00, 6'h00, 4'b0000, 6'h00, 1});
        vecs.push_back('{6'h39, 6'h00, 4'b1101, 6'h1F, 1});
        vecs.push_back('{6'h20, 6'h00, 4'b1100, 6'h00, 1});
        vecs.push_back('{6'h39, 6'h00, 4'b0100, 6'h10, 1});
        vecs.push_back('{6'h00, 6'h16, 4'b0000, 6'h10, 1});
        vecs.push_back('{6'h00, 6'h1B, 4'b0000, 6'h0B, 1});
        vecs.push_back('{6'h00, 6'h11, 4'b0000, 6'h11, 1});
        vecs.push_back('{6'h00, 6'h12, 4'b0000, 6'h02, MUL_LAT});
        vecs.push_back('{6'h00, 6'h14, 4'b0000, 6'h10, 1});
        vecs.push_back('{6'h00, 6'h19, 4'b0000, 6'h10, 1});
        vecs.push_back('{6'h00, 6'h1A, 4'b0000, 6'h0A, 1});
        vecs.push_back('{6'h22, 6'h00, 4'b0100, 6'h1F, 1});
        vecs.push_back('{6'h31, 6'h00, 4'b0100, 6'h1F, 1});
        vecs.push_back('{6'h10, 6'h00, 4'b0100, 6'h1F, 1});
        vecs.push_back('{6'h0C, 6'h00, 4'b0100, 6'h0C, 1});
        vecs.push_back('{6'h00, 6'h03, 4'b0000, 6'h03, DIV_LAT});
        vecs.push_back('{6'h00, 6'h01, 4'b0000, 6'h01, 1});
        foreach (vecs[i]) begin
            send(vecs[i].opcode, vecs[i].opex, vecs[i].ctrl, vecs[i].op, vecs[i].lat, a1);
        end
        repeat (10) @(posedge clk);
        #1;

        // MULT followed by a request held during the busy window
        send(6'h00, 6'h02, 4'b0000, 6'h02, MUL_LAT, a1);
        send(6'h00, 6'h00, 4'b0000, 6'h00, 1, a2);
        check("mult_b2b_gap", 32'(a2 - a1), 32'(MUL_LAT));
        repeat (3) @(posedge clk);
        #1;

        // Flush in IDLE blocks acceptance
        opex     = 6'h00;
        ctrl     = 4'b0000;
        in_valid = 1'b1;
        flush    = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        check("idle_flush_issue", 32'(issue), 32'd0);
        check("idle_flush_alu_op", 32'(alu_op), 32'h00);

        // DIVI aborted by flush in its third busy cycle
        send(6'h00, 6'h03, 4'b0000, 6'h03, DIV_LAT, a1);
        repeat (2) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_busy", 32'(busy), 32'd0);
        check("flush_in_ready", 32'(in_ready), 32'd1);
        repeat (7) @(posedge clk);
        #1;
        check("flush_alu_op", 32'(alu_op), 32'h03);

        // Asynchronous reset in the middle of a MULT
        send(6'h00, 6'h02, 4'b0000, 6'h02, MUL_LAT, a1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_busy", 32'(busy), 32'd0);
        check("async_alu_op", 32'(alu_op), 32'h1F);
        check("async_in_ready", 32'(in_ready), 32'd1);
        check("async_done", 32'(done), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send(6'h00, 6'h00, 4'b0000, 6'h00, 1, a1);
        repeat (2) @(posedge clk);
        #1;

        // Single-cycle instance treats DIVI as one cycle
        send(6'h00, 6'h03, 4'b0000, 6'h03, DIV_LAT, a1);
        check("se_issue", 32'(issue_se), 32'd1);
        check("se_done", 32'(done_se), 32'd1);
        check("se_alu_op", 32'(alu_op_se), 32'h03);
        check("se_busy_now", 32'(busy_se), 32'd0);

        repeat (12) @(posedge clk);
        #1;
        check("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ula_seq_ctrl.md
Name: ula_seq_ctrl

Overview:
Registered, multi-cycle successor to the combinational ALU-op decoder. It decodes opcode/opex/ctrl into an ALU operation code, registers it behind a valid/ready handshake, and sequences multi-cycle operations (MULT, DIVI). While a multi-cycle operation runs, it holds the op stable and back-pressures the control unit. It sits between the main control unit and the ALU.

Parameters:
OP_W, 6, width of alu_op output (>=5; upper bits above bit 4 zero-filled)
MUL_LAT, 4, cycles MULT occupies the ALU (>=1; 1 = single-cycle)
DIV_LAT, 8, cycles DIVI occupies the ALU (>=1)
MULTI_EN, 1, 0 = every op treated as single-cycle (MUL_LAT/DIV_LAT ignored)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous, active-low reset
in_valid  in  1  decode request present
in_ready  out  1  block can accept a request this cycle
opcode  in  6  instruction opcode
opex  in  6  register-form extended opcode
ctrl  in  4  [0] jump, [1] branch, [2] immediate form, [3] address/shift add
flush  in  1  abort in-flight operation
alu_op  out  OP_W  registered ALU operation code
issue  out  1  1-cycle strobe: new alu_op valid
busy  out  1  multi-cycle op in progress
done  out  1  1-cycle strobe: current op completes

Behaviour:
- Decode (combinational, 5-bit result d), first match wins:
  ctrl[0]|ctrl[1] -> 0x1F (NOP).
  ctrl[3] -> 0x00 (ADD).
  opcode[5:4]==2'b10 or opcode[5:3]==3'b110 -> 0x1F.
  ctrl[2]=1: opcode==0x39 -> 0x10 (MOVE); opcode[4:1]==4'b1000 -> 0x1F; else {0,opcode[3:0]}.
  ctrl[2]=0: 0x14<=opex<=0x19 -> 0x10; opex<0x12 -> opex[4:0]; else {0,opex[3:0]}.
- Latency L(d): MULTI_EN=1 and d==0x02 -> MUL_LAT; MULTI_EN=1 and d==0x03 -> DIV_LAT; else 1.
- Reset: alu_op=0x1F, issue=0, busy=0, done=0, in_ready=1, state IDLE, counter 0.
- States: IDLE, BUSY.
- IDLE: in_ready=1. Accept on in_valid & in_ready & !flush at edge k.
  - Cycle k+1: alu_op=d, issue=1.
  - If L=1: done=1 in k+1, stay IDLE.
  - If L>1: go BUSY, counter=L-1, busy=1 and in_ready=0 for cycles k+1..k+L-1.
- BUSY: counter decrements each cycle. When counter reaches 0 (cycle k+L): done=1, busy=0, in_ready=1, return IDLE. Back-to-back accept is allowed in that same cycle.
- alu_op holds its value until the next accept. It is not changed by flush or by done.
- in_valid while in_ready=0 is ignored. The requester must hold the request; the block stores nothing extra (no queue).
- flush in IDLE: blocks acceptance that cycle. flush in BUSY: next cycle IDLE, busy=0, in_ready=1, no done pulse.
- flush on the same cycle as the final BUSY count: flush wins, no done.
- Counter width is clog2(max(MUL_LAT,DIV_LAT)+1).
- rst_n low mid-BUSY: all outputs return to reset values immediately (asynchronous). No done is generated.
- issue and done are never high for more than one consecutive cycle per op.

Test Plan:
1. Reg ADD: ctrl=0, opex=0x00, in_valid 1 cycle -> next cycle alu_op=0x00, issue=1, done=1, in_ready stays 1.
2. MULT, MUL_LAT=4: ctrl=0, opex=0x02 accepted at k -> issue at k+1; busy and in_ready=0 at k+1..k+3; done at k+4; new request held from k+1 is accepted at k+4.
3. Decode priority: ctrl=4'b1101, opcode=0x39 -> 0x1F. ctrl=4'b1100, opcode=0x20 -> 0x00. ctrl=4'b0100, opcode=0x39 -> 0x10. ctrl=0, opex=0x16 -> 0x10. ctrl=0, opex=0x1B -> 0x0B.
4. DIVI with flush, DIV_LAT=8: flush asserted at k+3 -> busy=0 at k+4, no done in k+4..k+10, alu_op still 0x03.
5. Async reset mid-BUSY: rst_n low at k+2 (between edges) -> busy=0, alu_op=0x1F, in_ready=1 immediately; after release, a fresh ADD decodes normally.
6. MULTI_EN=0: opex=0x03 -> issue and done in the same cycle, busy never asserted.
